// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the FPGA-side I2C target blocks.
// Contents: FSM state encoding for the write-only target receiver and the
// R/W bit values carried in the address byte.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DATA_ACK  = 3'd4,
    ST_WAIT_STOP = 3'd5
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus synchroniser and event detector.
// Brings SCL/SDA into the CLK domain through a SYNC_LEN-flop chain plus one
// history flop, and flags bus events from the synchronised values.
// Ports:
//   CLK, RST   system clock, synchronous active-high reset
//   scl, sda   raw bus pins
//   scl_rise   SCL 0->1
//   scl_fall   SCL 1->0
//   start_det  SDA 1->0 while SCL high
//   stop_det   SDA 0->1 while SCL high
//   sda_s      synchronised SDA
module i2c_bus_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_LEN-1:0] scl_sync_reg;
  logic [SYNC_LEN-1:0] sda_sync_reg;
  logic                scl_hist_reg;
  logic                sda_hist_reg;
  logic                scl_s;

  // Reset to the idle-bus level (both high) so leaving reset on a quiet bus
  // produces no spurious START/STOP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_LEN-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_LEN-2:0], sda};
      scl_hist_reg <= scl_sync_reg[SYNC_LEN-1];
      sda_hist_reg <= sda_sync_reg[SYNC_LEN-1];
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_LEN-1];
  assign sda_s     = sda_sync_reg[SYNC_LEN-1];
  assign scl_rise  =  scl_s & ~scl_hist_reg;
  assign scl_fall  = ~scl_s &  scl_hist_reg;
  assign start_det =  scl_s &  sda_hist_reg & ~sda_s;
  assign stop_det  =  scl_s & ~sda_hist_reg &  sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver.
// Matches a 7-bit address with R/W=0, ACKs it and every following data byte
// by pulling SDA low, and presents each received byte with a one-CLK strobe.
// Read requests and foreign addresses are NACKed and ignored until STOP/START.
// Ports:
//   CLK, RST    system clock (>= 8x SCL), synchronous active-high reset
//   SCL         I2C clock from the master
//   SDA         open-drain I2C data (driven 0 or z only)
//   Data_Out    last received data byte
//   Data_Valid  one-CLK pulse with each new Data_Out
//   Addr_Match  high from address ACK until STOP/repeated START
//   RW_Bit      R/W bit of the last address byte
//   Busy        high between START and STOP
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h19,
  parameter int         SYNC_LEN = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] Data_Out,
  output logic       Data_Valid,
  output logic       Addr_Match,
  output logic       RW_Bit,
  output logic       Busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .scl       (SCL),
    .sda       (SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       sda_drive_low_reg, sda_drive_low_next;
  logic [7:0] data_out_reg, data_out_next;
  logic       data_valid_reg, data_valid_next;
  logic       addr_match_reg, addr_match_next;
  logic       rw_bit_reg, rw_bit_next;
  logic       busy_reg, busy_next;
  logic [7:0] byte_in;

  // Byte as it stands once the current bit is shifted in.
  assign byte_in = {shift_reg[6:0], sda_s};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg         <= ST_IDLE;
      shift_reg         <= '0;
      bit_cnt_reg       <= '0;
      sda_drive_low_reg <= 1'b0;
      data_out_reg      <= '0;
      data_valid_reg    <= 1'b0;
      addr_match_reg    <= 1'b0;
      rw_bit_reg        <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      shift_reg         <= shift_next;
      bit_cnt_reg       <= bit_cnt_next;
      sda_drive_low_reg <= sda_drive_low_next;
      data_out_reg      <= data_out_next;
      data_valid_reg    <= data_valid_next;
      addr_match_reg    <= addr_match_next;
      rw_bit_reg        <= rw_bit_next;
      busy_reg          <= busy_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    shift_next         = shift_reg;
    bit_cnt_next       = bit_cnt_reg;
    sda_drive_low_next = sda_drive_low_reg;
    data_out_next      = data_out_reg;
    data_valid_next    = 1'b0;
    addr_match_next    = addr_match_reg;
    rw_bit_next        = rw_bit_reg;
    busy_next          = busy_reg;

    // Bus conditions override bit handling and abort any ACK in progress.
    if (start_det) begin
      state_next         = ST_ADDR;
      shift_next         = '0;
      bit_cnt_next       = '0;
      sda_drive_low_next = 1'b0;
      addr_match_next    = 1'b0;
      busy_next          = 1'b1;
    end else if (stop_det) begin
      state_next         = ST_IDLE;
      bit_cnt_next       = '0;
      sda_drive_low_next = 1'b0;
      addr_match_next    = 1'b0;
      busy_next          = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (state_reg == ST_ADDR) begin
                rw_bit_next = byte_in[0];
                if (byte_in[7:1] == ADDR && byte_in[0] == I2C_RW_WRITE) begin
                  state_next      = ST_ADDR_ACK;
                  addr_match_next = 1'b1;
                end else begin
                  state_next = ST_WAIT_STOP;
                end
              end else begin
                data_out_next   = byte_in;
                data_valid_next = 1'b1;
                state_next      = ST_DATA_ACK;
              end
            end
          end
        end
        // First SCL fall (end of bit 8) starts the ACK; the next fall
        // (end of the 9th clock) releases it.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_drive_low_reg) begin
              sda_drive_low_next = 1'b1;
            end else begin
              sda_drive_low_next = 1'b0;
              state_next         = ST_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA        = sda_drive_low_reg ? 1'b0 : 1'bz;
  assign Data_Out   = data_out_reg;
  assign Data_Valid = data_valid_reg;
  assign Addr_Match = addr_match_reg;
  assign RW_Bit     = rw_bit_reg;
  assign Busy       = busy_reg;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx: a behavioural I2C master drives the bus, a
// queue holds the data bytes the target should deliver, and a monitor pops
// and compares on every Data_Valid.
module tb_i2c_target_rx;

  localparam int Q = 80;  // quarter SCL period (8 CLK)

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;    // 1 = released
  wire        sda_bus;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_match;
  logic       rw_bit;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_target_rx dut (
    .CLK        (clk),
    .RST        (rst),
    .SCL        (m_scl),
    .SDA        (sda_bus),
    .Data_Out   (data_out),
    .Data_Valid (data_valid),
    .Addr_Match (addr_match),
    .RW_Bit     (rw_bit),
    .Busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (data_valid) begin
      check("dv_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("data_out", data_out, exp_q.pop_front());
    end
  end

  task automatic i2c_start();
    m_sda = 1'b1; #(Q);
    m_scl = 1'b1; #(Q);
    m_sda = 1'b0; #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(Q);
    m_scl = 1'b1; #(Q);
    m_sda = 1'b1; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    #(Q);
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
  endtask

  task automatic ack_clock(input string tag, input logic exp_sda);
    m_sda = 1'b1; #(Q);
    m_scl = 1'b1; #(Q);
    check(tag, sda_bus, exp_sda);
    #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_match", addr_match, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", rw_bit, 0);
    check("rst_sda", sda_bus, 1);
    @(negedge clk); rst = 1'b0;
    #(Q);

    // Single write 0x32 / 0xF0
    i2c_start();
    check("t1_busy", busy, 1);
    write_byte(8'h32);
    ack_clock("t1_addr_ack", 1'b0);
    check("t1_match", addr_match, 1);
    exp_q.push_back(8'hF0);
    write_byte(8'hF0);
    ack_clock("t1_data_ack", 1'b0);
    i2c_stop();
    check("t1_busy_after", busy, 0);
    check("t1_match_after", addr_match, 0);
    check("t1_data_hold", data_out, 8'hF0);

    // Wrong address 0x66
    i2c_start();
    write_byte(8'h66);
    ack_clock("t2_addr_nack", 1'b1);
    check("t2_match", addr_match, 0);
    write_byte(8'h55);
    ack_clock("t2_data_nack", 1'b1);
    i2c_stop();
    check("t2_data_out", data_out, 8'hF0);

    // Read request 0x33
    i2c_start();
    write_byte(8'h33);
    ack_clock("t3_addr_nack", 1'b1);
    check("t3_rw", rw_bit, 1);
    check("t3_match", addr_match, 0);
    write_byte(8'h77);
    ack_clock("t3_data_nack", 1'b1);
    i2c_stop();

    // Multi-byte
    i2c_start();
    write_byte(8'h32);
    ack_clock("t4_addr_ack", 1'b0);
    check("t4_rw", rw_bit, 0);
    exp_q.push_back(8'hA5); write_byte(8'hA5); ack_clock("t4_ack_a5", 1'b0);
    exp_q.push_back(8'h3C); write_byte(8'h3C); ack_clock("t4_ack_3c", 1'b0);
    exp_q.push_back(8'hFF); write_byte(8'hFF); ack_clock("t4_ack_ff", 1'b0);
    i2c_stop();

    // Repeated START after 4 data bits
    i2c_start();
    write_byte(8'h32);
    ack_clock("t5_addr_ack", 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    check("t5_match_rs", addr_match, 0);
    check("t5_busy_rs", busy, 1);
    write_byte(8'h32);
    ack_clock("t5_addr_ack2", 1'b0);
    exp_q.push_back(8'h5A); write_byte(8'h5A); ack_clock("t5_ack_5a", 1'b0);
    i2c_stop();

    // RST during DATA_ACK
    i2c_start();
    write_byte(8'h32);
    ack_clock("t6_addr_ack", 1'b0);
    exp_q.push_back(8'hC3);
    write_byte(8'hC3);
    m_sda = 1'b1; #(Q/2);
    check("t6_ack_driven", sda_bus, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_sda", sda_bus, 1);
    check("t6_rst_data", data_out, 8'h00);
    check("t6_rst_match", addr_match, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", data_valid, 0);
    @(negedge clk); rst = 1'b0;
    #(Q);
    i2c_start();
    write_byte(8'h32);
    ack_clock("t6_addr_ack2", 1'b0);
    exp_q.push_back(8'h11); write_byte(8'h11); ack_clock("t6_ack_11", 1'b0);
    i2c_stop();
    check("t6_data_out", data_out, 8'h11);
    check("t6_busy", busy, 0);

    repeat (10) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
